// File: rtl/cp0_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_int_sequencer
// Description : CP0 interrupt entry/return sequencer. Conditions dev_irq into
//               hwint pulses and drives the EXL-set/EPC-write, vector and ERET
//               return sequence. Define CP0_INT_SYNC_EN to add a two-flop
//               synchronizer on dev_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_int_sequencer #(
    parameter logic [31:0] VEC_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  dev_irq,
    input  logic        intreq,
    input  logic        inst_done,
    input  logic        eret,
    input  logic [31:0] pc_next,
    input  logic [31:0] epc,
    output logic [5:0]  hwint,
    output logic        exlset,
    output logic        exlclr,
    output logic        cp0_we,
    output logic [31:0] pc_save,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [2:0]  irq_id,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_SAVE     = 3'd2,
        ST_VECTOR   = 3'd3,
        ST_HANDLER  = 3'd4,
        ST_RETURN   = 3'd5
    } state_t;

    state_t      r_state;
    logic [5:0]  w_lvl;
    logic [5:0]  r_lvl;
    logic [5:0]  r_hwint;
    logic [2:0]  w_irq_id;
    logic        r_exlset;
    logic        r_exlclr;
    logic        r_cp0_we;
    logic        r_stall;
    logic        r_redirect;
    logic        r_busy;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_pc_save;

    // ------------------------------------------------------------------------
    // Interrupt line conditioning
    // ------------------------------------------------------------------------
`ifdef CP0_INT_SYNC_EN
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= dev_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = r_sync2;
`else
    assign w_lvl = dev_irq;
`endif

    // r_lvl doubles as the edge-detect history and the level seen by irq_id
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lvl   <= '0;
            r_hwint <= '0;
        end else begin
            r_lvl   <= w_lvl;
            r_hwint <= w_lvl & ~r_lvl;
        end
    end

    always_comb begin
        w_irq_id = 3'd7;
        for (int i = 5; i >= 0; i--) begin
            if (r_lvl[i]) begin
                w_irq_id = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry/return sequencer; outputs are registered alongside the state so
    // each strobe is a clean one-cycle pulse aligned with its state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_exlset      <= 1'b0;
            r_exlclr      <= 1'b0;
            r_cp0_we      <= 1'b0;
            r_stall       <= 1'b0;
            r_redirect    <= 1'b0;
            r_busy        <= 1'b0;
            r_redirect_pc <= '0;
            r_pc_save     <= '0;
        end else begin
            r_exlset      <= 1'b0;
            r_exlclr      <= 1'b0;
            r_cp0_we      <= 1'b0;
            r_stall       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (intreq && !(eret && inst_done)) begin
                        r_state <= ST_WAIT_BND;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_BND: begin
                    // intreq is deliberately not re-checked: entry is atomic
                    if (inst_done) begin
                        r_pc_save <= pc_next;
                        r_state   <= ST_SAVE;
                        r_exlset  <= 1'b1;
                        r_cp0_we  <= 1'b1;
                        r_stall   <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    r_state       <= ST_VECTOR;
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= VEC_ADDR;
                    r_stall       <= 1'b1;
                end
                ST_VECTOR: begin
                    r_state <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (eret && inst_done) begin
                        r_state       <= ST_RETURN;
                        r_exlclr      <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= epc;
                        r_stall       <= 1'b1;
                    end
                end
                ST_RETURN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hwint       = r_hwint;
    assign exlset      = r_exlset;
    assign exlclr      = r_exlclr;
    assign cp0_we      = r_cp0_we;
    assign pc_save     = r_pc_save;
    assign stall       = r_stall;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign irq_id      = w_irq_id;
    assign busy        = r_busy;

    // ------------------------------------------------------------------------
    // Strobe invariants
    // ------------------------------------------------------------------------
    a_exl_excl: assert property (@(posedge clk) disable iff (!reset)
        !(exlset && exlclr));
    a_exlset_pulse: assert property (@(posedge clk) disable iff (!reset)
        exlset |=> !exlset);
    a_exlclr_pulse: assert property (@(posedge clk) disable iff (!reset)
        exlclr |=> !exlclr);
    a_we_pulse: assert property (@(posedge clk) disable iff (!reset)
        cp0_we |=> !cp0_we);
    a_redirect_pulse: assert property (@(posedge clk) disable iff (!reset)
        redirect |=> !redirect);

endmodule
`default_nettype wire

// File: tb/tb_cp0_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_int_sequencer
// Description : Scoreboard bench for cp0_int_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_int_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  dev_irq;
    logic        intreq;
    logic        inst_done;
    logic        eret;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic [5:0]  hwint;
    logic        exlset;
    logic        exlclr;
    logic        cp0_we;
    logic [31:0] pc_save;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  irq_id;
    logic        busy;

    typedef struct packed {
        logic [5:0]  hwint;
        logic        exlset;
        logic        exlclr;
        logic        cp0_we;
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic [31:0] pc_save;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    cp0_int_sequencer #(.VEC_ADDR(32'h0000_4180)) dut (
        .clk         (clk),
        .reset       (reset),
        .dev_irq     (dev_irq),
        .intreq      (intreq),
        .inst_done   (inst_done),
        .eret        (eret),
        .pc_next     (pc_next),
        .epc         (epc),
        .hwint       (hwint),
        .exlset      (exlset),
        .exlclr      (exlclr),
        .cp0_we      (cp0_we),
        .pc_save     (pc_save),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_id      (irq_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [5:0] h, logic set, logic clr, logic we,
                                logic st, logic rd, logic [31:0] rpc, logic [31:0] ps);
        exp_t e;
        e.hwint       = h;
        e.exlset      = set;
        e.exlclr      = clr;
        e.cp0_we      = we;
        e.stall       = st;
        e.redirect    = rd;
        e.redirect_pc = rpc;
        e.pc_save     = ps;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle carrying a strobe or hwint pulse consumes one record
    initial begin
        exp_t act;
        exp_t exp;
        forever begin
            @(negedge clk);
            if (reset && (hwint != 6'd0 || exlset || exlclr || cp0_we || redirect)) begin
                act = {hwint, exlset, exlclr, cp0_we, stall, redirect, redirect_pc, pc_save};
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    exp = q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL event_mismatch: got %h expected %h", act, exp);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        dev_irq   = 6'h3F;
        intreq    = 1'b0;
        inst_done = 1'b0;
        eret      = 1'b0;
        pc_next   = '0;
        epc       = '0;

        // Reset state while lines are held high
        repeat (3) tick();
        check("rst_hwint", hwint, 0);
        check("rst_strobes", {exlset, exlclr, cp0_we, stall, redirect, busy}, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_pc_save", pc_save, 0);
        check("rst_irq_id", irq_id, 7);

        q.push_back(mk(6'h3F, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        reset = 1'b1;
        tick();
        check("hwint_rise", hwint, 6'h3F);
        tick();
        check("hwint_one_cycle", hwint, 0);
        check("irq_id_all", irq_id, 0);

        // Falling lines produce no pulse; priority picks lowest index
        dev_irq = 6'b100100;
        tick();
        check("irq_id_2", irq_id, 2);

        dev_irq = 6'b000011;
        q.push_back(mk(6'b000011, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        tick();
        tick();
        dev_irq = 6'b000000;
        tick();
        check("irq_id_none", irq_id, 7);

        // eret in IDLE, also coinciding with intreq: nothing happens
        intreq = 1'b1; eret = 1'b1; inst_done = 1'b1;
        tick();
        intreq = 1'b0; eret = 1'b0; inst_done = 1'b0;
        check("idle_eret_busy", busy, 0);
        tick();
        check("idle_eret_strobes", {exlclr, redirect}, 0);

        // Normal entry
        intreq = 1'b1;
        tick();
        check("wait_busy", busy, 1);
        check("wait_stall", stall, 0);
        pc_next = 32'h0000_3010; inst_done = 1'b1;
        q.push_back(mk(0, 1, 0, 1, 1, 0, 32'h0, 32'h0000_3010));
        q.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0000_4180, 32'h0000_3010));
        tick();
        inst_done = 1'b0; intreq = 1'b0;
        check("save_pc_save", pc_save, 32'h0000_3010);
        tick();
        check("vector_pc", redirect_pc, 32'h0000_4180);
        tick();
        check("handler_stall", {busy, stall}, 2'b10);

        // intreq ignored in HANDLER, then return
        intreq = 1'b1;
        repeat (3) tick();
        check("handler_hold", busy, 1);
        intreq = 1'b0; eret = 1'b1; inst_done = 1'b1; epc = 32'h0000_3010;
        q.push_back(mk(0, 0, 1, 0, 1, 1, 32'h0000_3010, 32'h0000_3010));
        tick();
        eret = 1'b0; inst_done = 1'b0;
        check("return_exlclr", exlclr, 1);
        tick();
        check("return_idle", busy, 0);

        // One-cycle intreq pulse; boundary coincides with eret
        intreq = 1'b1;
        tick();
        intreq = 1'b0;
        repeat (3) tick();
        check("pulse_wait_busy", busy, 1);
        pc_next = 32'h0000_2020; inst_done = 1'b1; eret = 1'b1;
        q.push_back(mk(0, 1, 0, 1, 1, 0, 32'h0, 32'h0000_2020));
        q.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0000_4180, 32'h0000_2020));
        tick();
        inst_done = 1'b0; eret = 1'b0;
        tick();
        tick();
        epc = 32'h0000_2024; eret = 1'b1; inst_done = 1'b1;
        q.push_back(mk(0, 0, 1, 0, 1, 1, 32'h0000_2024, 32'h0000_2020));
        tick();
        eret = 1'b0; inst_done = 1'b0;
        tick();
        check("pulse_return_idle", busy, 0);

        // Reset asserted while in SAVE
        intreq = 1'b1;
        tick();
        intreq = 1'b0; pc_next = 32'h0000_5000; inst_done = 1'b1;
        q.push_back(mk(0, 1, 0, 1, 1, 0, 32'h0, 32'h0000_5000));
        tick();
        inst_done = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_exlset_we", {exlset, cp0_we}, 0);
        check("midrst_busy_stall", {busy, stall, redirect}, 0);
        check("midrst_pc_save", pc_save, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tick();
        check("midrst_idle", {busy, redirect}, 0);

        repeat (3) tick();
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
